serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
Bit-serial N-bit adder/subtractor controller that sequences a single 1-bit full-adder cell, processing one bit per clock, LSB first.
- Subtraction uses two's complement: b inverted per bit, initial carry-in = 1.
- Accepts a start/busy/done handshake from the arithmetic test harness or sequencer.
- Area-minimal alternative to the ripple adders in the arithmetic circuits library.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge
op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: result/flags valid
result  output  WIDTH  sum or difference, modulo 2^WIDTH
cout  output  1  raw carry out of MSB (subtract: 1 = no borrow, 0 = borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: FSM to IDLE; busy, done, result, cout, ovf = 0; all internal registers cleared.
  - Reset is asynchronous: outputs go to 0 immediately, not at the next edge.
  - Mid-operation reset aborts with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at an edge (edge E0):
  - Latch a into shift register SA.
  - Latch b into SB, stored as ~b when op=1.
  - Carry register C set to op; bit counter cleared to 0.
  - Go to RUN; busy=1.
- IDLE or DONE with start=0: go to (or stay in) IDLE.
- RUN, each edge:
  - One full-adder evaluation: s = SA[0]^SB[0]^C, carry as standard.
  - s shifted into the MSB of an internal result shift register SR.
  - SA and SB shifted right; C updated; counter incremented.
  - Carry into the MSB (C before the last bit) saved for ovf.
- RUN, last bit (counter = WIDTH-1, edge E_WIDTH):
  - Go to DONE; busy=0; done=1 for exactly one cycle.
  - result <= final SR; cout <= final carry; ovf <= carry_into_MSB ^ carry_out.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH clocks after the start edge. busy is high for exactly WIDTH cycles.
- result, cout, ovf update only at the DONE transition. They hold their values through later operations until the next completion.
- start while busy (RUN): ignored; latched operands unchanged.
- start in the DONE cycle: accepted (back-to-back). done pulses once and busy rises at the same edge.
- a, b, op may change freely after the start edge without effect.
- The existing 1-bit full-adder cell is instantiated for the per-bit arithmetic. The controller owns all state: counter width is $clog2(WIDTH), with wrap handled by the FSM exit.

Test Plan (WIDTH=8):
- Add: start, op=0, a=8'h25, b=8'h17 -> after 8 clocks done=1 for 1 cycle; result=8'h3C, cout=0, ovf=0; busy high exactly 8 cycles.
- Subtract with borrow: op=1, a=8'h05, b=8'h09 -> result=8'hFC, cout=0, ovf=0.
- Signed overflow: op=1, a=8'h80, b=8'h01 -> result=8'h7F, cout=1, ovf=1. Also op=0, a=8'h7F, b=8'h01 -> result=8'h80, cout=0, ovf=1.
- Carry wrap: op=0, a=8'hFF, b=8'h01 -> result=8'h00, cout=1, ovf=0.
- Handshake:
  - start pulsed at RUN bit 3 with different operands -> ignored; first result unchanged.
  - start held during the DONE cycle -> second op accepted; its done arrives 8 clocks later.
  - result stays stable between the two done pulses.
- Reset mid-RUN (after 4 bits, asserted between edges) -> busy/done/result/cout/ovf = 0 immediately; no done pulse. A new start after release (op=1, a=8'h10, b=8'h10) -> result=8'h00, cout=1.

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller driving one 1-bit full-adder cell.
// Operands are consumed LSB first, one bit per clock; flags are set on completion.
module serial_addsub_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_ovf;
  logic             w_s;
  logic             w_co;

  serial_addsub_fa u_fa (
    .i_a (r_sa[0]),
    .i_b (r_sb[0]),
    .i_c (r_c),
    .o_s (w_s),
    .o_c (w_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= op ? ~b : b;
            r_c     <= op;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= {w_s, r_sr[WIDTH-1:1]};
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          // r_c here is the carry into the MSB
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_res   <= {w_s, r_sr[WIDTH-1:1]};
            r_cout  <= w_co;
            r_ovf   <= r_c ^ w_co;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_res;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: arithmetic reference model,
// latency and handshake checks, mid-run reset.
module tb_serial_addsub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  logic [W+1:0] q[$];
  logic [W+1:0] hold = '0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed as {cout, ovf, result}
  function automatic logic [W+1:0] model(input bit o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    int sx, sy, t;
    logic [W-1:0] r;
    logic c, v;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o) begin
      r = x - y;
      c = (x >= y);
      t = sx - sy;
    end else begin
      r = x + y;
      c = (int'(x) + int'(y)) > 255;
      t = sx + sy;
    end
    v = (t > 127) || (t < -128);
    return {c, v, r};
  endfunction

  initial begin
    wait (armed);
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = '0;
      end else if (done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          hold = q.pop_front();
          chk("result", 32'(result), 32'(hold[W-1:0]));
          chk("cout", 32'(cout), 32'(hold[W+1]));
          chk("ovf", 32'(ovf), 32'(hold[W]));
        end
      end else begin
        chk("hold_out", 32'({cout, ovf, result}), 32'(hold));
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic start_op(input bit o, input logic [W-1:0] x,
                          input logic [W-1:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    op = 1'($urandom);
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Counts busy cycles until done; optionally pokes start mid-run.
  task automatic wait_done(input bit poke);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) n++;
      if (poke && n == 4) begin
        start = 1'b1;
        op = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end else if (poke && n == 5) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(n), 32'(W));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic run(input bit o, input logic [W-1:0] x,
                     input logic [W-1:0] y);
    @(negedge clk);
    start_op(o, x, y);
    wait_done(1'b0);
  endtask

  initial begin
    int nd;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'({cout, ovf, result}), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    armed = 1'b1;
    @(negedge clk);

    run(1'b0, 8'h25, 8'h17);
    run(1'b1, 8'h05, 8'h09);
    run(1'b1, 8'h80, 8'h01);
    run(1'b0, 8'h7F, 8'h01);
    run(1'b0, 8'hFF, 8'h01);

    // start pulsed mid-run must be ignored
    @(negedge clk);
    start_op(1'b0, 8'h3A, 8'h51);
    wait_done(1'b1);

    // back-to-back: start held during the done cycle
    run(1'b1, 8'h44, 8'h11);
    start_op(1'b0, 8'h12, 8'h34);
    wait_done(1'b0);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      start_op(1'($urandom), W'($urandom), W'($urandom));
      wait_done(1'b0);
    end

    run(1'b0, 8'h7F, 8'h01);

    // reset asserted between edges after four bits
    @(negedge clk);
    start_op(1'b1, 8'h5A, 8'h33);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_out", 32'({cout, ovf, result}), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("no_done_after_rst", 32'(nd), 32'd0);

    run(1'b1, 8'h10, 8'h10);
    @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
